// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: raw pad inputs -> multi-flop synchronizer -> per-bit
// debounce filter -> clean gpio_in_o vector, plus sticky rising/falling edge
// status (write-1-to-clear) and a level interrupt.
// Optional feature macro: GPIO_IN_GLITCH_CNT_EN adds a saturating 16-bit
// counter of cycles in which at least one bit abandoned a debounce count.
// SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1.
module gpio_in_conditioner #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] gpio_in_o,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic             status_clr_en,
    input  logic [WIDTH-1:0] status_clr_mask,
    output logic [WIDTH-1:0] edge_status,
    output logic             irq
`ifdef GPIO_IN_GLITCH_CNT_EN
    ,
    output logic [15:0]      glitch_count,
    input  logic             glitch_clr
`endif
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] edge_status_q;
    logic [WIDTH-1:0] edge_status_d;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // Synchronizer shift chain; the last stage is the only one the filter sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= '0;
            end
        end else begin
            sync_chain_q[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= sync_chain_q[s-1];
            end
        end
    end

    // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive samples that differ from the current stable level; any
    // sample matching the stable level discards the partial count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state: accepted levels and in-progress counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Edge detection on accepted levels; a new set beats a same-cycle clear.
    always_comb begin
        edge_set      = (stable_d & ~stable_q & rise_en) |
                        (~stable_d & stable_q & fall_en);
        clr_vec       = status_clr_en ? status_clr_mask : '0;
        edge_status_d = (edge_status_q & ~clr_vec) | edge_set;
    end

    // Sticky edge status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_status_q <= '0;
        end else begin
            edge_status_q <= edge_status_d;
        end
    end

    assign gpio_in_o   = stable_q;
    assign edge_status = edge_status_q;
    assign irq         = |edge_status_q;

`ifdef GPIO_IN_GLITCH_CNT_EN
    logic [WIDTH-1:0] abort_vec;
    logic [15:0]      glitch_cnt_q;
    logic [15:0]      glitch_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A bit aborts when its sample returns to the stable level mid-count.
    always_comb begin
        abort_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            abort_vec[i] = (sync_q[i] == stable_q[i]) && (cnt_q[i] != '0);
        end
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (|abort_vec) begin
            glitch_cnt_d = sat_inc16(glitch_cnt_q);
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    // Saturating glitch event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_count = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). A history-based reference model tracks the expected
// outputs; directed scenarios also check fixed expected values.
module tb_gpio_in_conditioner;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pad_in = '0;
    logic [W-1:0] rise_en = '0;
    logic [W-1:0] fall_en = '0;
    logic         status_clr_en = 1'b0;
    logic [W-1:0] status_clr_mask = '0;
    logic         glitch_clr = 1'b0;
    logic [W-1:0] gpio_in_o;
    logic [W-1:0] edge_status;
    logic         irq;
`ifdef GPIO_IN_GLITCH_CNT_EN
    logic [15:0]  glitch_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_dl [SYNC];
    logic [W-1:0] m_hist [$];
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_status = '0;
    int           m_glitch = 0;

    gpio_in_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .pad_in(pad_in), .gpio_in_o(gpio_in_o),
        .rise_en(rise_en), .fall_en(fall_en),
        .status_clr_en(status_clr_en), .status_clr_mask(status_clr_mask),
        .edge_status(edge_status), .irq(irq)
`ifdef GPIO_IN_GLITCH_CNT_EN
        , .glitch_count(glitch_count), .glitch_clr(glitch_clr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One clock edge; the model applies the rules to the inputs at that edge.
    // A new level is accepted when the last DEB synchronized samples all
    // differ from the accepted level; a glitch is a sample back at the
    // accepted level right after a differing sample.
    task automatic tick();
        logic [W-1:0] s, old, nxt, ab, set, clr;
        bit all_diff;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < SYNC; k++) m_dl[k] = '0;
            m_hist.delete();
            m_stable = '0;
            m_status = '0;
            m_glitch = 0;
        end else begin
            s = m_dl[SYNC-1];
            for (int k = SYNC-1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = pad_in;
            old = m_stable;
            ab  = '0;
            if (m_hist.size() > 0) ab = ~(s ^ old) & (m_hist[m_hist.size()-1] ^ old);
            if (glitch_clr) m_glitch = 0;
            else if (ab != '0 && m_glitch < 65535) m_glitch++;
            m_hist.push_back(s);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            nxt = old;
            if (m_hist.size() == DEB) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (m_hist[k][b] == old[b]) all_diff = 1'b0;
                    if (all_diff) nxt[b] = ~old[b];
                end
            end
            set = (nxt & ~old & rise_en) | (~nxt & old & fall_en);
            clr = status_clr_en ? status_clr_mask : '0;
            m_status = (m_status & ~clr) | set;
            m_stable = nxt;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL reset_gpio: got %h expected %h", gpio_in_o, 8'h00); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected %h", edge_status, 8'h00); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_edge();
        pad_in  = 8'h01;
        rise_en = 8'hFF;
        tick();  // edge N
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL clean_hold_%0d: got %h expected %h", j, gpio_in_o, 8'h00); end
        end
        tick();  // edge N+5
        checks++; if (gpio_in_o !== 8'h01) begin errors++; $display("FAIL clean_gpio: got %h expected %h", gpio_in_o, 8'h01); end
        checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL clean_status: got %h expected %h", edge_status, 8'h01); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL clean_irq: got %b expected 1", irq); end
        checks++; if (gpio_in_o !== m_stable) begin errors++; $display("FAIL clean_model: got %h expected %h", gpio_in_o, m_stable); end
    endtask

    task automatic test_glitch();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
`ifdef GPIO_IN_GLITCH_CNT_EN
        checks++; if (glitch_count !== 16'h0000) begin errors++; $display("FAIL glitch_clr0: got %h expected %h", glitch_count, 16'h0000); end
`endif
        pad_in = 8'h05;
        repeat (3) tick();
        pad_in = 8'h01;
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++; if (gpio_in_o[2] !== 1'b0) begin errors++; $display("FAIL glitch_bit2_%0d: got %b expected 0", j, gpio_in_o[2]); end
            checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL glitch_status_%0d: got %h expected %h", j, edge_status, 8'h01); end
        end
`ifdef GPIO_IN_GLITCH_CNT_EN
        checks++; if (glitch_count !== 16'h0001) begin errors++; $display("FAIL glitch_count: got %h expected %h", glitch_count, 16'h0001); end
`endif
    endtask

    task automatic test_falling();
        status_clr_en = 1'b1; status_clr_mask = 8'hFF;
        tick();
        status_clr_en = 1'b0; status_clr_mask = 8'h00;
        checks++; if (edge_status !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL fall_preclear: got %h/%b expected 00/0", edge_status, irq); end
        pad_in = 8'h00; fall_en = 8'h00;
        tick();  // edge N
        repeat (4) tick();
        checks++; if (gpio_in_o !== 8'h01) begin errors++; $display("FAIL fall_hold: got %h expected %h", gpio_in_o, 8'h01); end
        tick();
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL fall_gpio: got %h expected %h", gpio_in_o, 8'h00); end
        checks++; if (edge_status !== 8'h00) begin errors++; $display("FAIL fall_disabled: got %h expected %h", edge_status, 8'h00); end
        rise_en = 8'h00; pad_in = 8'h01;
        repeat (6) tick();
        checks++; if (gpio_in_o !== 8'h01 || edge_status !== 8'h00) begin errors++; $display("FAIL fall_rise_masked: got %h/%h expected 01/00", gpio_in_o, edge_status); end
        pad_in = 8'h00; fall_en = 8'h01;
        repeat (6) tick();
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL fall2_gpio: got %h expected %h", gpio_in_o, 8'h00); end
        checks++; if (edge_status !== 8'h01) begin errors++; $display("FAIL fall_enabled: got %h expected %h", edge_status, 8'h01); end
    endtask

    task automatic test_w1c();
        rise_en = 8'hFF; pad_in = 8'h02;
        repeat (6) tick();
        checks++; if (edge_status !== 8'h03) begin errors++; $display("FAIL w1c_setup: got %h expected %h", edge_status, 8'h03); end
        status_clr_en = 1'b1; status_clr_mask = 8'h01;
        tick();
        checks++; if (edge_status !== 8'h02 || irq !== 1'b1) begin errors++; $display("FAIL w1c_bit0: got %h/%b expected 02/1", edge_status, irq); end
        status_clr_mask = 8'h02;
        tick();
        checks++; if (edge_status !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL w1c_bit1: got %h/%b expected 00/0", edge_status, irq); end
        status_clr_en = 1'b0; status_clr_mask = 8'h00;
        pad_in = 8'h12;
        tick();  // edge N
        repeat (4) tick();
        checks++; if (gpio_in_o !== 8'h02) begin errors++; $display("FAIL coll_hold: got %h expected %h", gpio_in_o, 8'h02); end
        status_clr_en = 1'b1; status_clr_mask = 8'h10;
        tick();  // edge N+5: set and clear together on bit 4
        status_clr_en = 1'b0; status_clr_mask = 8'h00;
        checks++; if (edge_status !== 8'h10) begin errors++; $display("FAIL coll_set_wins: got %h expected %h", edge_status, 8'h10); end
        checks++; if (gpio_in_o !== 8'h12) begin errors++; $display("FAIL coll_gpio: got %h expected %h", gpio_in_o, 8'h12); end
    endtask

    task automatic test_multibit();
        pad_in = 8'h00;
        repeat (6) tick();
        status_clr_en = 1'b1; status_clr_mask = 8'hFF;
        tick();
        status_clr_en = 1'b0; status_clr_mask = 8'h00;
        pad_in = 8'hA5;
        tick();  // edge N
        repeat (4) tick();
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL multi_hold: got %h expected %h", gpio_in_o, 8'h00); end
        tick();
        checks++; if (gpio_in_o !== 8'hA5) begin errors++; $display("FAIL multi_gpio: got %h expected %h", gpio_in_o, 8'hA5); end
        checks++; if (edge_status !== 8'hA5) begin errors++; $display("FAIL multi_status: got %h expected %h", edge_status, 8'hA5); end
        pad_in = 8'h00;
        repeat (6) tick();
        pad_in = 8'hA5;
        tick();  // edge N
        tick();
        tick();
        rst = 1'b1;
        tick();  // edge N+3 with reset
        rst = 1'b0;
        checks++; if (gpio_in_o !== 8'h00 || edge_status !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL midrst_clear: got %h/%h/%b expected 00/00/0", gpio_in_o, edge_status, irq); end
        repeat (5) tick();  // edges N+4..N+8
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL midrst_hold: got %h expected %h", gpio_in_o, 8'h00); end
        tick();  // edge N+9
        checks++; if (gpio_in_o !== 8'hA5) begin errors++; $display("FAIL midrst_gpio: got %h expected %h", gpio_in_o, 8'hA5); end
        checks++; if (edge_status !== 8'hA5) begin errors++; $display("FAIL midrst_status: got %h expected %h", edge_status, 8'hA5); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 500; n++) begin
            if (hold == 0) begin
                pad_in  = pad_in ^ W'($urandom_range(0, 255) & $urandom_range(0, 255));
                hold    = $urandom_range(1, 7);
                rise_en = W'($urandom_range(0, 255));
                fall_en = W'($urandom_range(0, 255));
            end
            hold--;
            status_clr_en   = ($urandom_range(0, 7) == 0);
            status_clr_mask = W'($urandom_range(0, 255));
            glitch_clr      = ($urandom_range(0, 31) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            tick();
            checks++; if (gpio_in_o !== m_stable) begin errors++; $display("FAIL rand_gpio_%0d: got %h expected %h", n, gpio_in_o, m_stable); end
            checks++; if (edge_status !== m_status) begin errors++; $display("FAIL rand_status_%0d: got %h expected %h", n, edge_status, m_status); end
            checks++; if (irq !== (m_status != '0)) begin errors++; $display("FAIL rand_irq_%0d: got %b expected %b", n, irq, (m_status != '0)); end
`ifdef GPIO_IN_GLITCH_CNT_EN
            checks++; if (glitch_count !== 16'(m_glitch)) begin errors++; $display("FAIL rand_glitch_%0d: got %h expected %h", n, glitch_count, 16'(m_glitch)); end
`endif
        end
        rst = 1'b0; status_clr_en = 1'b0; glitch_clr = 1'b0;
    endtask

`ifdef GPIO_IN_GLITCH_CNT_EN
    task automatic test_saturation();
        pad_in = 8'h00;
        repeat (8) tick();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        // Bits 0 and 1 pulse on alternate cycles so one of them aborts every cycle.
        for (int n = 0; n < 65600; n++) begin
            pad_in = n[0] ? 8'h02 : 8'h01;
            tick();
        end
        checks++; if (glitch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected %h", glitch_count, 16'hFFFF); end
        checks++; if (gpio_in_o !== 8'h00) begin errors++; $display("FAIL sat_gpio: got %h expected %h", gpio_in_o, 8'h00); end
        pad_in = 8'h00; glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        checks++; if (glitch_count !== 16'h0000) begin errors++; $display("FAIL sat_clr: got %h expected %h", glitch_count, 16'h0000); end
    endtask
`endif

    initial begin
        for (int k = 0; k < SYNC; k++) m_dl[k] = '0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_falling();
        test_w1c();
        test_multibit();
        test_random();
`ifdef GPIO_IN_GLITCH_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Input-side conditioning stage placed directly upstream of the GPIO register block.
- Takes raw, asynchronous pad inputs and passes each bit through a synchronizer and then a per-bit debounce filter.
- Drives the resulting clean, stable vector into the GPIO block's gpio_in.
- Also detects rising and falling edges on the debounced signals, latches them into a sticky status register with write-1-to-clear, and raises a level interrupt.

Parameters:
- WIDTH, 32: number of GPIO input bits.
- SYNC_STAGES, 2: synchronizer flop depth; must be 2 or more.
- DEBOUNCE_CYCLES, 16: consecutive differing cycles required to accept a new level; must be 1 or more. Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- pad_in  input  WIDTH  raw asynchronous pad levels.
- gpio_in_o  output  WIDTH  debounced stable levels; feeds the GPIO block's gpio_in.
- rise_en  input  WIDTH  per-bit enable for rising-edge capture.
- fall_en  input  WIDTH  per-bit enable for falling-edge capture.
- status_clr_en  input  1  write strobe for status clear.
- status_clr_mask  input  WIDTH  write-1-to-clear mask; used only when status_clr_en=1.
- edge_status  output  WIDTH  sticky edge-event flags.
- irq  output  1  OR-reduction of edge_status.

Behaviour:
- Reset: all synchronizer flops, stable vector, debounce counters and edge_status go to 0. Therefore gpio_in_o=0 and irq=0 in the cycle after rst is sampled high.
- Reset mid-debounce discards any count in progress.
- After reset, a pad held high is treated as a new 0->1 transition: it is debounced normally and, if rise_en is set, reported as a rising edge.
- Synchronizer:
  - pad_in passes through SYNC_STAGES flops per bit; sync_q is the last stage.
  - No combinational path from pad_in to any output.
- Debounce, per bit i, every clock edge:
  - If sync_q[i] equals stable[i]: cnt[i] is set to 0. An aborted count is a glitch and is discarded.
  - Else if cnt[i] equals DEBOUNCE_CYCLES-1: stable[i] is set to sync_q[i] and cnt[i] to 0.
  - Otherwise: cnt[i] increments by 1.
- Latency: a pad level first sampled at edge N and held thereafter appears on gpio_in_o after edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults that is N+17.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach gpio_in_o.
- gpio_in_o is stable[] driven directly from flops.
- Edge capture, on the same edge that stable[i] changes:
  - A 0->1 change with rise_en[i]=1 sets edge_status[i].
  - A 1->0 change with fall_en[i]=1 sets edge_status[i].
  - The enables are sampled on that edge only; enabling later does not report a past edge.
- Clear: on an edge with status_clr_en=1, each edge_status bit whose mask bit is 1 is cleared.
- Simultaneous set and clear on the same bit in the same cycle: set wins and the bit stays 1.
- edge_status bits stay 1 until cleared or reset; repeated edges have no further effect.
- irq = OR of all edge_status bits, derived combinationally from registered status. It rises the cycle after the edge-causing clock edge and falls the cycle after the clearing edge.
- All bits are fully independent; any combination may transition in the same cycle.

Optional Feature:
- Macro: GPIO_IN_GLITCH_CNT_EN.
- When defined:
  - Adds port glitch_count, output, 16 bits.
  - Adds port glitch_clr, input, 1 bit.
  - glitch_count increments by 1 on each edge where at least one bit aborts a nonzero count, i.e. sync_q equals stable while cnt is nonzero.
  - glitch_count saturates at 0xFFFF.
  - glitch_clr=1 sets it to 0, with priority over the increment. Reset also sets it to 0.
- When not defined: both ports and the counter are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset and clean edge: after reset, gpio_in_o=0x00, edge_status=0, irq=0. Drive pad_in=0x01 sampled at edge N, rise_en=0xFF. Expect:
  - gpio_in_o=0x01 after edge N+5.
  - edge_status=0x01 after the same edge.
  - irq=1.
  - gpio_in_o=0x00 through edge N+4.
- Glitch rejection: pad_in bit 2 high for 3 cycles then low. Expect gpio_in_o bit 2 stays 0, edge_status unchanged, and glitch_count=1 when the macro is defined.
- Falling edge with enables: after stable 0x01, drive pad_in=0x00 with fall_en=0x00. Expect:
  - gpio_in_o=0x00 after 5 edges.
  - edge_status bit 0 remains at its prior value, with no new set.
  - Repeating with fall_en=0x01 sets bit 0.
- W1C and collision:
  - With edge_status=0x03, apply status_clr_en=1 and mask=0x01. Expect 0x02 and irq=1. Then mask=0x02: expect 0x00, irq=0 the next cycle.
  - A clear coinciding with a new rising edge on bit 4 leaves bit 4 set.
- Multi-bit and reset mid-count:
  - pad_in 0x00->0xA5 in one cycle sets gpio_in_o=0xA5 on a single edge, N+5.
  - Asserting rst at N+3 instead yields gpio_in_o=0x00. The new count restarts after rst falls, and 0xA5 appears 4 edges after the first post-reset compare.
- Saturation (macro defined): force more than 65535 glitches. Expect glitch_count holds at 0xFFFF; glitch_clr returns it to 0x0000.
